dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have no parameters; data-memory interface fixed at 32-bit address, 32-bit word-addressed data.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  fetch port request (read only).
REQ-005 i_addr  input  32  fetch byte address, word aligned.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid / i_rdata  output  1/32  fetch response, one cycle after i_gnt.
REQ-008 d_req / d_we  input  1/1  load-store request; d_we=1 store.
REQ-009 d_addr / d_wdata  input  32/32  byte address; store data in low bits.
REQ-010 d_memsz / d_uns  input  2/1  size 00 byte, 01 half, 10 word, 11 reserved; d_uns=1 zero-extends loads.
REQ-011 d_gnt / d_rvalid / d_rdata / d_err  output  1/1/32/1  accept, load response, load data, misalign/size fault.
REQ-012 m_addr / m_wdata / m_wmem / m_rmem  output  32/32/1/1  to word memory (async read, sync write on m_wmem).
REQ-013 m_rdata  input  32  word read combinationally at m_addr.

Function
REQ-014 SHALL run FSM states IDLE and RMW; IDLE accepts at most one request per cycle.
REQ-015 In IDLE, only one of i_gnt/d_gnt SHALL assert; d port wins when both request (fixed priority) unless MEM_RR_ARB_EN.
REQ-016 Requester SHALL hold req and payload stable until its gnt; gnt is a single-cycle pulse.
REQ-017 Granted read (fetch or load): m_rmem=1, m_addr=request address; response data registered, rvalid pulses next cycle.
REQ-018 Load data SHALL be lane-selected by addr[1:0], sign-extended from bit 7/15 unless d_uns=1.
REQ-019 Granted word store: m_wmem=1 same cycle, m_wdata=d_wdata; no RMW.
REQ-020 Granted byte/half store: cycle 0 reads word, merges d_wdata lanes into a held register, FSM->RMW; cycle 1 m_wmem=1 with merged word at held address; FSM->IDLE.
REQ-021 In RMW, i_gnt and d_gnt SHALL be 0; new requests wait.
REQ-022 Half with addr[0]=1, word with addr[1:0]!=0, or memsz=11: d_gnt=1, d_err pulses next cycle, no m_rmem/m_wmem, d_rvalid=0.
REQ-023 Fetch with i_addr[1:0]!=0 SHALL be served from the word at i_addr[31:2] (low bits ignored).
REQ-024 m_wmem and m_rmem SHALL never assert in the same cycle; memory outputs zero when idle.

Reset
REQ-025 rst SHALL force FSM=IDLE; all gnt, rvalid, err, m_wmem, m_rmem=0; rdata and held RMW registers=0.
REQ-026 rst asserted in RMW SHALL abandon the write; no m_wmem after reset release.
REQ-027 First grant possible in the first clk edge after rst deasserts.

Configuration
REQ-028 Macro MEM_RR_ARB_EN defined: round-robin, last-granted port loses a tie; pointer resets to favour d port.
REQ-029 Macro MEM_RR_ARB_EN undefined: fixed priority d over i, fetch may starve.

Verification
REQ-030 Word store d_addr=0x10 wdata=0xDEADBEEF, then load word 0x10 -> d_rvalid, d_rdata=0xDEADBEEF.
REQ-031 Byte store 0x80 at 0x13 over 0x11223344, load byte signed 0x13 -> 0xFFFFFF80; word load -> 0x80223344; store took 2 cycles, m_wmem once.
REQ-032 i_req and d_req held together 4 cycles, no macro -> d_gnt every IDLE cycle, i_gnt=0; with MEM_RR_ARB_EN -> grants alternate d,i,d,i.
REQ-033 Half load at 0x21 -> d_err pulse, no m_rmem, memory unchanged.
REQ-034 rst asserted during RMW cycle of half store -> target word unchanged, all outputs 0.
REQ-035 Half store 0xABCD at 0x22 then load half unsigned 0x22 -> 0x0000ABCD; fetch of 0x20 during RMW stalls one cycle then returns merged word.

Source files
------------

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: fetch, load/store and word-memory signals of the data-memory arbiter.
interface dmem_arb_if;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_uns, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_memsz;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_wmem, m_rmem;
  logic [31:0] m_addr, m_wdata, m_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_memsz, d_uns, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           m_addr, m_wdata, m_wmem, m_rmem
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_memsz, d_uns, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           m_addr, m_wdata, m_wmem, m_rmem
  );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb: arbitrates fetch and load/store ports onto one word memory, with read-modify-write for sub-word stores.
// Define MEM_RR_ARB_EN for round-robin arbitration; default is fixed priority d over i.
module dmem_arb (
  input logic       clk,
  input logic       rst,
  dmem_arb_if.slave bus
);
  typedef enum logic {IDLE, RMW} state_t;
  state_t      state_q;
  logic [31:0] hold_addr_q, hold_data_q, i_rdata_q, d_rdata_q;
  logic        i_rvalid_q, d_rvalid_q, d_err_q;
  logic [31:0] merged_d, load_d, mask, lanes;
  logic [15:0] half_w;
  logic [7:0]  byte_w;
  logic [1:0]  a;
  logic        idle, pick_d, i_gnt, d_gnt, mis, d_rd, d_wr, d_sub;
  assign idle = state_q == IDLE;
  assign a    = bus.d_addr[1:0];
`ifdef MEM_RR_ARB_EN
  logic rr_q;
  assign pick_d = !bus.i_req || rr_q;
`else
  assign pick_d = 1'b1;
`endif
  assign d_gnt = idle && bus.d_req && pick_d;
  assign i_gnt = idle && bus.i_req && !d_gnt;
  assign mis   = bus.d_memsz == 2'b11 || (bus.d_memsz == 2'b01 && a[0]) ||
                 (bus.d_memsz == 2'b10 && a != 2'b00);
  assign d_rd  = d_gnt && !mis && !bus.d_we;
  assign d_wr  = d_gnt && !mis && bus.d_we && bus.d_memsz == 2'b10;
  assign d_sub = d_gnt && !mis && bus.d_we && bus.d_memsz != 2'b10;
  // Sub-word store: replicate the store data into every lane, then keep only the addressed lane.
  always_comb begin
    mask     = bus.d_memsz == 2'b00 ? 32'h0000_00FF << {a, 3'b000} : 32'h0000_FFFF << {a[1], 4'b0000};
    lanes    = bus.d_memsz == 2'b00 ? {4{bus.d_wdata[7:0]}} : {2{bus.d_wdata[15:0]}};
    merged_d = (bus.m_rdata & ~mask) | (lanes & mask);
    byte_w   = 8'(bus.m_rdata >> {a, 3'b000});
    half_w   = 16'(bus.m_rdata >> {a[1], 4'b0000});
    load_d   = bus.d_memsz == 2'b00 ? {{24{!bus.d_uns && byte_w[7]}}, byte_w} :
               bus.d_memsz == 2'b01 ? {{16{!bus.d_uns && half_w[15]}}, half_w} : bus.m_rdata;
  end
  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign bus.m_rmem   = i_gnt || d_rd || d_sub;
  assign bus.m_wmem   = !idle || d_wr;
  assign bus.m_addr   = !idle ? hold_addr_q : i_gnt ? bus.i_addr :
                        (d_rd || d_wr || d_sub) ? bus.d_addr : 32'h0;
  assign bus.m_wdata  = !idle ? hold_data_q : d_wr ? bus.d_wdata : 32'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
`ifdef MEM_RR_ARB_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      state_q    <= d_sub ? RMW : IDLE;
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_rd;
      d_err_q    <= d_gnt && mis;
      if (d_sub) begin
        hold_addr_q <= bus.d_addr;
        hold_data_q <= merged_d;
      end
      if (i_gnt) i_rdata_q <= bus.m_rdata;
      if (d_rd) d_rdata_q <= load_d;
`ifdef MEM_RR_ARB_EN
      if (d_gnt) rr_q <= 1'b0;
      else if (i_gnt) rr_q <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: table-driven load/store vectors plus arbitration, RMW-stall and reset-in-RMW sequences.
module tb_dmem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_arb_if bus ();
  dmem_arb dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:63];
  assign bus.m_rdata = mem[bus.m_addr[7:2]];
  always @(posedge clk) if (bus.m_wmem) mem[bus.m_addr[7:2]] <= bus.m_wdata;
  typedef struct {logic err; logic [31:0] data;} exp_t;
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata, exp;
    logic        err;
  } vec_t;
  exp_t dq[$], iq[$];
  int total = 0, bad = 0, wmem_cnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    exp_t e;
    if (bus.m_wmem) wmem_cnt++;
    chk("mem_excl", {31'b0, bus.m_wmem & bus.m_rmem}, 32'h0);
    if (bus.d_rvalid || bus.d_err) begin
      if (dq.size() == 0) chk("d_spurious", {30'b0, bus.d_rvalid, bus.d_err}, 32'h0);
      else begin
        e = dq.pop_front();
        chk("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
        chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, !e.err});
        if (!e.err) chk("d_rdata", bus.d_rdata, e.data);
      end
    end
    if (bus.i_rvalid) begin
      if (iq.size() == 0) chk("i_spurious", {31'b0, bus.i_rvalid}, 32'h0);
      else begin
        e = iq.pop_front();
        chk("i_rdata", bus.i_rdata, e.data);
      end
    end
  end
  task automatic d_op(input vec_t v, input string name);
    logic got = 1'b0;
    bus.d_req = 1'b1; bus.d_we = v.we; bus.d_memsz = v.sz; bus.d_uns = v.uns;
    bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.d_gnt;
    end
    if (!got) chk({name, "_gnt_timeout"}, 32'h0, 32'h1);
    else if (v.err) begin
      dq.push_back('{1'b1, 32'h0});
      chk({name, "_err_no_mem"}, {30'b0, bus.m_rmem, bus.m_wmem}, 32'h0);
    end else if (!v.we) dq.push_back('{1'b0, v.exp});
    @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_i_gnt"}, {31'b0, bus.i_gnt}, 32'h0);
    chk({name, "_d_gnt"}, {31'b0, bus.d_gnt}, 32'h0);
    chk({name, "_i_rvalid"}, {31'b0, bus.i_rvalid}, 32'h0);
    chk({name, "_d_rvalid"}, {31'b0, bus.d_rvalid}, 32'h0);
    chk({name, "_d_err"}, {31'b0, bus.d_err}, 32'h0);
    chk({name, "_m_wmem"}, {31'b0, bus.m_wmem}, 32'h0);
    chk({name, "_m_rmem"}, {31'b0, bus.m_rmem}, 32'h0);
    chk({name, "_m_addr"}, bus.m_addr, 32'h0);
    chk({name, "_i_rdata"}, bus.i_rdata, 32'h0);
    chk({name, "_d_rdata"}, bus.d_rdata, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[22];
    vec_t v;
    int c0;
    logic ed;
    //        we    sz     uns   addr      wdata         exp           err
    tv[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    tv[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0};
    tv[3]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0};
    tv[4]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
    tv[5]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0};
    tv[6]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80223344, 1'b0};
    tv[7]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8022, 1'b0};
    tv[8]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h00003344, 1'b0};
    tv[9]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h00000033, 1'b0};
    tv[10] = '{1'b0, 2'b01, 1'b0, 32'h21, 32'h0,        32'h0,        1'b1};
    tv[11] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1};
    tv[12] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'h0,        1'b1};
    tv[13] = '{1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, 32'h0,        1'b1};
    tv[14] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h00000000, 1'b0};
    tv[15] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0,        1'b0};
    tv[16] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h0000ABCD, 1'b0};
    tv[17] = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'hFFFFABCD, 1'b0};
    tv[18] = '{1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFFFF7F, 32'h0,        1'b0};
    tv[19] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hABCD007F, 1'b0};
    tv[20] = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h00000012, 32'h0,        1'b0};
    tv[21] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hABCD127F, 1'b0};
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_memsz = 2'b00; bus.d_uns = 1'b0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 22; i++) d_op(tv[i], $sformatf("vec%0d", i));
    repeat (3) @(negedge clk);
    // Simultaneous requests straight after reset; first grant on the first edge after release.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_idle("rst2");
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h12;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_memsz = 2'b10; bus.d_uns = 1'b0; bus.d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef MEM_RR_ARB_EN
      ed = (k % 2) == 0;
`else
      ed = 1'b1;
`endif
      chk($sformatf("arb%0d_d_gnt", k), {31'b0, bus.d_gnt}, {31'b0, ed});
      chk($sformatf("arb%0d_i_gnt", k), {31'b0, bus.i_gnt}, {31'b0, !ed});
      if (bus.d_gnt) dq.push_back('{1'b0, 32'h80223344});
      if (bus.i_gnt) iq.push_back('{1'b0, 32'h80223344});
      @(negedge clk);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    // Half store RMW with a fetch to the same word waiting behind it.
    @(posedge clk);
    #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_memsz = 2'b01; bus.d_addr = 32'h32; bus.d_wdata = 32'h00001357;
    bus.i_req = 1'b1; bus.i_addr = 32'h33;
    @(negedge clk);
    c0 = wmem_cnt;
    chk("rmw_c0_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    chk("rmw_c0_i_gnt", {31'b0, bus.i_gnt}, 32'h0);
    chk("rmw_c0_m_wmem", {31'b0, bus.m_wmem}, 32'h0);
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    @(negedge clk);
    chk("rmw_c1_i_gnt", {31'b0, bus.i_gnt}, 32'h0);
    chk("rmw_c1_d_gnt", {31'b0, bus.d_gnt}, 32'h0);
    chk("rmw_c1_m_wmem", {31'b0, bus.m_wmem}, 32'h1);
    chk("rmw_c1_m_wdata", bus.m_wdata, 32'h13570000);
    @(negedge clk);
    chk("rmw_c2_i_gnt", {31'b0, bus.i_gnt}, 32'h1);
    if (bus.i_gnt) iq.push_back('{1'b0, 32'h13570000});
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rmw_wmem_once", wmem_cnt - c0, 32'h1);
    // Reset while the RMW write is pending must drop the write.
    @(posedge clk);
    #1 c0 = wmem_cnt;
    v = '{1'b1, 2'b01, 1'b0, 32'h3E, 32'h0000BEEF, 32'h0, 1'b0};
    d_op(v, "rstrmw");
    #2 rst = 1'b1;
    #1;
    chk_idle("rstrmw");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstrmw_mem", mem[15], 32'h0);
    chk("rstrmw_wmem_cnt", wmem_cnt - c0, 32'h0);
    @(posedge clk);
    #1;
    v = '{1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0};
    d_op(v, "rstrmw_ld");
    repeat (3) @(negedge clk);
    chk("d_queue_empty", dq.size(), 32'h0);
    chk("i_queue_empty", iq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
